// File: rtl/ex_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the EX stage: restoring division,
// one quotient bit per cycle, with its own forwarding mux and a pipeline stall request.
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic [XLEN-1:0] rs2_data_ex,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] wb_result,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy,
  output logic            stall_req,
  output logic [1:0]      state_dbg_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            is_rem_q, is_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] a_sel, b_sel, a_abs, b_abs;
  logic            signed_op, a_neg, b_neg, div_zero, overflow, special, accept;
  logic [XLEN:0]   shifted, trial, rem_step;
  logic            q_bit;
  logic [XLEN-1:0] quot_step, quot_fix, rem_fix;

  // Handshake: valid_in is held by the stalled ID/EX register for the whole op;
  // an op is taken only in IDLE without flush, and the unit answers with one
  // result_valid cycle (DONE), during which the pipeline advances past it.
  always_comb begin
    a_sel = (forward_a == 2'b10) ? mem_result :
            (forward_a == 2'b01) ? wb_result  : rs1_data_ex;
    b_sel = (forward_b == 2'b10) ? mem_result :
            (forward_b == 2'b01) ? wb_result  : rs2_data_ex;
    signed_op = ~op[0];
    a_neg     = signed_op & a_sel[XLEN-1];
    b_neg     = signed_op & b_sel[XLEN-1];
    a_abs     = a_neg ? (~a_sel + 1'b1) : a_sel;
    b_abs     = b_neg ? (~b_sel + 1'b1) : b_sel;
    div_zero  = (b_sel == '0);
    overflow  = signed_op && (a_sel == {1'b1, {(XLEN-1){1'b0}}}) && (b_sel == '1);
    special   = div_zero | overflow;
    accept    = (state_q == S_IDLE) && valid_in && !flush;
  end

  // A set top bit of the remainder means the shifted value already exceeds the divisor.
  always_comb begin
    shifted   = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
    trial     = shifted - {1'b0, dvs_q};
    q_bit     = rem_q[XLEN] | ~trial[XLEN];
    rem_step  = q_bit ? trial : shifted;
    quot_step = {quot_q[XLEN-2:0], q_bit};
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_rem_d = is_rem_q;
    result_d = result_q;
    quot_fix = '0;
    rem_fix  = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_rem_d = op[1];
          dvs_d    = b_abs;
          count_d  = '0;
          if (special) begin
            // Load the architectural answer directly; no sign fixup needed.
            quot_d  = div_zero ? '1 : a_sel;
            rem_d   = div_zero ? {1'b0, a_sel} : '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            quot_d  = a_abs;
            rem_d   = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        quot_d  = quot_step;
        rem_d   = rem_step;
        count_d = count_q + 1'b1;
        if (count_q == CW'(XLEN-1)) begin
          count_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) begin
      quot_fix = qneg_d ? (~quot_d + 1'b1) : quot_d;
      rem_fix  = rneg_d ? (~rem_d[XLEN-1:0] + 1'b1) : rem_d[XLEN-1:0];
      result_d = is_rem_d ? rem_fix : quot_fix;
    end

    if (flush) begin
      state_d  = S_IDLE;
      count_d  = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
    end
  end

  assign result       = result_q;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q == S_BUSY);
  assign stall_req    = !rst && (accept || (state_q == S_BUSY));
  assign state_dbg_o  = state_q;

endmodule
